systolic_skew_feeder: RTL and testbench
=======================================

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter N, default 4: number of systolic lanes (rows of A, columns of B).
REQ-002 Parameter W, default 16: operand width per lane.
REQ-003 Parameter KW, default 8: width of tile-length field.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begin a tile; sampled only in IDLE.
REQ-007 k_len  input  KW  number of operand vectors in the tile; sampled with start.
REQ-008 in_valid  input  1  in_a/in_b carry a vector.
REQ-009 in_ready  output  1  feeder accepts a vector this cycle.
REQ-010 in_a  input  N*W  lane i A operand at bits [i*W +: W].
REQ-011 in_b  input  N*W  lane i B operand at bits [i*W +: W].
REQ-012 out_a  output  N*W  skewed A operands to array west edge.
REQ-013 out_b  output  N*W  skewed B operands to array north edge.
REQ-014 out_lane_valid  output  N  bit i set when lane i carries an accepted operand.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 done  output  1  one-cycle pulse at tile completion.

Function
REQ-017 FSM states IDLE, LOAD, FLUSH, DONE; encoding shall be in the shared package.
REQ-018 IDLE: start=1 and k_len!=0 -> LOAD, vector counter cleared; start=1 and k_len==0 -> DONE; otherwise remain.
REQ-019 in_ready shall be 1 only in LOAD; handshake completes when in_valid & in_ready in the same cycle.
REQ-020 LOAD: each accepted vector increments the counter; the accept that makes count equal k_len -> FLUSH.
REQ-021 LOAD cycle with in_valid=0 shall inject an all-zero vector with lane valid bits 0 (bubble), keeping downstream accumulators unchanged.
REQ-022 Lane i shall pass through exactly i+1 register stages: an operand accepted at cycle t appears on lane i outputs at cycle t+1+i.
REQ-023 Lane valid bits shall travel with their operands through the same stages.
REQ-024 FLUSH shall inject zero vectors for exactly 2*N-2 cycles, counted by a flush counter, then -> DONE.
REQ-025 DONE shall assert done for one cycle, then -> IDLE.
REQ-026 start asserted outside IDLE shall be ignored; k_len changes outside IDLE shall be ignored.
REQ-027 Operands shall pass unmodified; no arithmetic on data; counter width KW, no wrap since count stops at k_len.
REQ-028 Outside LOAD, skew stage inputs shall be zero with valid 0, so the pipeline empties.

Reset
REQ-029 Reset shall force state IDLE, both counters 0, all skew registers and lane valid bits 0.
REQ-030 Reset values: out_a=0, out_b=0, out_lane_valid=0, in_ready=0, busy=0, done=0.
REQ-031 Reset asserted mid-tile shall discard the tile with no done pulse; operation resumes on a later start.

Structure
REQ-032 Shared package shall hold the FSM state typedef, defaults for N/W/KW and the FLUSH_CYCLES = 2*N-2 expression.
REQ-033 A sub-module skew_line (parameterised depth, W-bit data plus valid bit) shall implement one lane, instantiated once per lane per operand.

Verification
REQ-034 N=4, start with k_len=3, in_valid held 1, lane values A=i+1 -> lane 0 data at cycles t+1..t+3, lane 3 at t+4..t+6; done exactly 1+3+6 cycles after LOAD entry.
REQ-035 k_len=2 with in_valid 1,0,1 -> bubble cycle shows zero data and lane valid 0 on every lane at its skewed slot; count still reaches 2.
REQ-036 start with k_len=0 -> done pulse one cycle after DONE entry, in_ready never 1, out_lane_valid stays 0.
REQ-037 start re-asserted during LOAD and FLUSH -> no state change, k_len unchanged, single done pulse.
REQ-038 Reset asserted during FLUSH with data in stages -> all outputs 0 next sample, no done pulse, subsequent tile k_len=1 behaves per REQ-022.
REQ-039 Back-to-back tiles: start on the cycle after done -> second tile accepted, no operand overlap between tiles on any lane.

Source files
------------

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder.
// Holds the FSM state encoding, default lane count / operand width /
// tile-length width, and the flush-length expression (2*N-2 cycles).
package systolic_skew_feeder_pkg;

  localparam int N_DEFAULT  = 4;
  localparam int W_DEFAULT  = 16;
  localparam int KW_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Cycles needed after the last accept so the deepest lane's last
  // operand clears the array: 2*N-2.
  function automatic int flush_cycles(input int n);
    return 2 * n - 2;
  endfunction

  localparam int FLUSH_CYCLES = flush_cycles(N_DEFAULT);

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Operand/control bundle between a tile source and the skew feeder.
// Signals:
//   start, k_len          tile request and tile length (vectors)
//   in_valid, in_ready    operand vector handshake
//   in_a, in_b            N lanes of W-bit operands, lane i at [i*W +: W]
//   out_a, out_b          skewed operands toward the array edges
//   out_lane_valid        per-lane operand valid
//   busy, done            status and one-cycle completion pulse
// Modports: master = tile source, slave = feeder.
interface systolic_skew_feeder_if #(
  parameter int N  = systolic_skew_feeder_pkg::N_DEFAULT,
  parameter int W  = systolic_skew_feeder_pkg::W_DEFAULT,
  parameter int KW = systolic_skew_feeder_pkg::KW_DEFAULT
);
  logic           start;
  logic [KW-1:0]  k_len;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_a;
  logic [N*W-1:0] in_b;
  logic [N*W-1:0] out_a;
  logic [N*W-1:0] out_b;
  logic [N-1:0]   out_lane_valid;
  logic           busy;
  logic           done;

  modport master (
    output start, k_len, in_valid, in_a, in_b,
    input  in_ready, out_a, out_b, out_lane_valid, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, in_a, in_b,
    output in_ready, out_a, out_b, out_lane_valid, busy, done
  );
endinterface

// File: rtl/systolic_skew_feeder_skew_line.sv
// One skew lane: a DEPTH-stage shift register carrying W-bit data and a
// valid bit side by side, so valid always lines up with its operand.
// Ports:
//   clk, reset   clock, async active-high reset (clears all stages)
//   din, vin     stage-0 input data / valid
//   dout, vout   last-stage data / valid
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         vin,
  output logic [W-1:0] dout,
  output logic         vout
);

  logic [W-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
      valid_q <= '0;
    end else begin
      data_q[0]  <= din;
      valid_q[0] <= vin;
      for (int s = 1; s < DEPTH; s++) begin
        data_q[s]  <= data_q[s-1];
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  assign dout = data_q[DEPTH-1];
  assign vout = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Systolic array operand feeder. Accepts k_len operand vectors per tile
// and skews them so lane i reaches the array i cycles after lane 0, then
// flushes zeros until the deepest lane has drained and pulses done.
// Ports:
//   clk, reset   clock, async active-high reset
//   bus          systolic_skew_feeder_if slave modport (handshake + data)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; k_len captured with start
// ST_LOAD  | in_ready high, accepting vectors until count == k_len
// ST_FLUSH | feeding zeros for 2*N-2 cycles to drain the skew lanes
// ST_DONE  | one cycle; done pulses on the following cycle, back to idle
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int W  = W_DEFAULT,
  parameter int KW = KW_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  systolic_skew_feeder_if.slave bus
);

  localparam int LOCAL_FLUSH = flush_cycles(N);
  localparam int FCW         = (LOCAL_FLUSH > 1) ? $clog2(LOCAL_FLUSH) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD =
    FCW'((LOCAL_FLUSH > 0) ? LOCAL_FLUSH - 1 : 0);

  state_t         state;
  logic [KW-1:0]  vec_cnt;
  logic [KW-1:0]  k_len_q;
  logic [FCW-1:0] flush_cnt;
  logic           in_ready_q;
  logic           busy_q;
  logic           done_q;
  logic           accept;

  // in_ready_q is high exactly while in ST_LOAD.
  assign accept = bus.in_valid & in_ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      vec_cnt    <= '0;
      k_len_q    <= '0;
      flush_cnt  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            k_len_q <= bus.k_len;
            vec_cnt <= '0;
            busy_q  <= 1'b1;
            if (bus.k_len != '0) begin
              state      <= ST_LOAD;
              in_ready_q <= 1'b1;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            vec_cnt <= vec_cnt + KW'(1);
            if (vec_cnt + KW'(1) == k_len_q) begin
              in_ready_q <= 1'b0;
              if (LOCAL_FLUSH == 0) begin
                state <= ST_DONE;
              end else begin
                state     <= ST_FLUSH;
                flush_cnt <= FLUSH_LOAD;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) state <= ST_DONE;
          else flush_cnt <= flush_cnt - FCW'(1);
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  // Stage-0 inputs are zero with valid low unless a vector is accepted,
  // which covers bubbles in LOAD and everything outside LOAD.
  logic [W-1:0] a_in  [N];
  logic [W-1:0] b_in  [N];
  logic [W-1:0] a_out [N];
  logic [W-1:0] b_out [N];
  logic [N-1:0] va_out;
  logic [N-1:0] vb_out;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
      if (accept) begin
        a_in[i] = bus.in_a[i*W +: W];
        b_in[i] = bus.in_b[i*W +: W];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_line #(.DEPTH(g + 1), .W(W)) u_a (
      .clk   (clk),
      .reset (reset),
      .din   (a_in[g]),
      .vin   (accept),
      .dout  (a_out[g]),
      .vout  (va_out[g])
    );
    skew_line #(.DEPTH(g + 1), .W(W)) u_b (
      .clk   (clk),
      .reset (reset),
      .din   (b_in[g]),
      .vin   (accept),
      .dout  (b_out[g]),
      .vout  (vb_out[g])
    );
  end

  logic [N*W-1:0] out_a_w;
  logic [N*W-1:0] out_b_w;

  always_comb begin
    out_a_w = '0;
    out_b_w = '0;
    for (int i = 0; i < N; i++) begin
      out_a_w[i*W +: W] = a_out[i];
      out_b_w[i*W +: W] = b_out[i];
    end
  end

  assign bus.out_a          = out_a_w;
  assign bus.out_b          = out_b_w;
  // Both lines of a lane carry identical valid; either would do.
  assign bus.out_lane_valid = va_out & vb_out;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int KW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  systolic_skew_feeder_if #(.N(N), .W(W), .KW(KW)) bus ();

  systolic_skew_feeder #(.N(N), .W(W), .KW(KW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           due;
  } exp_t;

  exp_t lane_q [N][$];
  int   done_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] val_a(input int t, input int v, input int i);
    return W'(t * 256 + v * 16 + i + 1);
  endfunction

  function automatic logic [W-1:0] val_b(input int t, input int v, input int i);
    return W'(16'h8000 + t * 256 + v * 16 + i + 1);
  endfunction

  // Scoreboard monitor: pops expected operands whenever a lane is valid.
  always @(negedge clk) begin
    exp_t e;
    logic [W-1:0] a_act, b_act;
    int d;
    for (int i = 0; i < N; i++) begin
      a_act = bus.out_a[i*W +: W];
      b_act = bus.out_b[i*W +: W];
      if (bus.out_lane_valid[i]) begin
        if (lane_q[i].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL lane%0d_unexpected @cycle %0d: got a=%0h b=%0h, expected no operand",
                   i, cyc, a_act, b_act);
        end else begin
          e = lane_q[i].pop_front();
          chk($sformatf("lane%0d_a", i), 32'(a_act), 32'(e.a));
          chk($sformatf("lane%0d_b", i), 32'(b_act), 32'(e.b));
          chk($sformatf("lane%0d_cycle", i), 32'(cyc), 32'(e.due));
        end
      end else begin
        chk($sformatf("lane%0d_idle_a", i), 32'(a_act), 32'h0);
        chk($sformatf("lane%0d_idle_b", i), 32'(b_act), 32'h0);
      end
    end
    if (bus.done) begin
      if (done_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_unexpected @cycle %0d: got done=1, expected 0", cyc);
      end else begin
        d = done_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(d));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_a"}, 32'(bus.out_a[31:0]) | 32'(bus.out_a[63:32]), 32'h0);
    chk({tag, "_out_b"}, 32'(bus.out_b[31:0]) | 32'(bus.out_b[63:32]), 32'h0);
    chk({tag, "_lane_valid"}, 32'(bus.out_lane_valid), 32'h0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_done"}, 32'(bus.done), 32'h0);
  endtask

  // One tile. vpat bit j = in_valid in the j-th LOAD cycle. restart keeps
  // start high (and k_len changed) through LOAD and most of FLUSH.
  // rst_after >= 0 asserts reset that many cycles into FLUSH.
  task automatic run_tile(input int tile, input int klen, input logic [7:0] vpat,
                          input bit restart, input int rst_after);
    int s, j, acc, last, done_cyc;
    exp_t e;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.k_len = KW'(klen);
    s = cyc;
    @(posedge clk); #1;
    bus.start = restart;
    if (restart) bus.k_len = KW'(9);
    if (klen == 0) begin
      done_q.push_back(s + 2);
      chk("zk_in_ready_done_state", 32'(bus.in_ready), 32'h0);
      chk("zk_busy_done_state", 32'(bus.busy), 32'h1);
      @(posedge clk); #1;
      chk("zk_in_ready_after", 32'(bus.in_ready), 32'h0);
      chk("zk_busy_after", 32'(bus.busy), 32'h0);
      chk("zk_lane_valid", 32'(bus.out_lane_valid), 32'h0);
      return;
    end
    acc  = 0;
    j    = 0;
    last = s;
    while (acc < klen && j < 8) begin
      chk("load_in_ready", 32'(bus.in_ready), 32'h1);
      chk("load_busy", 32'(bus.busy), 32'h1);
      bus.in_valid = vpat[j];
      for (int i = 0; i < N; i++) begin
        bus.in_a[i*W +: W] = vpat[j] ? val_a(tile, acc, i) : W'(16'hDEAD);
        bus.in_b[i*W +: W] = vpat[j] ? val_b(tile, acc, i) : W'(16'hBEEF);
      end
      if (vpat[j]) begin
        for (int i = 0; i < N; i++) begin
          e.a   = val_a(tile, acc, i);
          e.b   = val_b(tile, acc, i);
          e.due = cyc + 1 + i;
          lane_q[i].push_back(e);
        end
        acc++;
        last = cyc;
      end
      j++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    chk("flush_in_ready", 32'(bus.in_ready), 32'h0);
    chk("flush_busy", 32'(bus.busy), 32'h1);
    if (rst_after >= 0) begin
      repeat (rst_after) begin
        @(posedge clk); #1;
      end
      reset = 1'b1;
      for (int i = 0; i < N; i++) lane_q[i].delete();
      done_q.delete();
      #1;
      check_all_zero("midtile_reset");
      repeat (2) @(posedge clk);
      #1;
      reset     = 1'b0;
      bus.start = 1'b0;
      return;
    end
    // last accept + 2N-2 flush cycles + DONE cycle + registered pulse
    done_cyc = last + 2 * N;
    done_q.push_back(done_cyc);
    while (cyc < done_cyc) begin
      if (cyc >= last + 4) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    chk("idle_busy_at_done", 32'(bus.busy), 32'h0);
    chk("done_pulse_high", 32'(bus.done), 32'h1);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.k_len    = '0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    run_tile(0, 3, 8'b0000_0111, 1'b0, -1);  // basic skew, A = i+1
    run_tile(1, 2, 8'b0000_0101, 1'b0, -1);  // bubble between vectors
    run_tile(2, 0, 8'b0000_0000, 1'b0, -1);  // empty tile
    run_tile(3, 3, 8'b0000_0111, 1'b1, -1);  // start/k_len ignored when busy
    run_tile(4, 3, 8'b0000_0111, 1'b0, 2);   // reset during FLUSH
    run_tile(5, 1, 8'b0000_0001, 1'b0, -1);  // single vector after reset
    run_tile(6, 2, 8'b0000_0011, 1'b0, -1);  // back-to-back pair
    run_tile(7, 4, 8'b0001_1011, 1'b0, -1);

    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("lane%0d_queue_drained", i), 32'(lane_q[i].size()), 32'h0);
    chk("done_queue_drained", 32'(done_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout @cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
